// File: rtl/cpu_mem_responder_pkg.sv
// Shared types and helpers for the CPU memory responder.
//   state_t      : controller state (IDLE / LOAD / RUN)
//   NOP_INSN     : word returned on the instruction port when nothing valid is fetched
//   WORD_W       : memory word width
//   decode_addr  : byte address -> word index plus in-range flag
package mem_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef struct packed {
        logic              in_range;
        logic [WORD_W-1:0] idx;
    } addr_dec_t;

    // aw = log2(depth in words). Byte lanes addr[1:0] are ignored; every bit
    // above the word index must be zero for the address to be in range.
    function automatic addr_dec_t decode_addr(input logic [WORD_W-1:0] addr, input int aw);
        addr_dec_t d;
        d.idx      = addr >> 2;
        d.in_range = ((addr >> (aw + 2)) == '0);
        return d;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// CPU-side and loader-side signal bundle of the memory responder.
//   master : CPU / loader side (drives addresses, write enable, loader stream)
//   slave  : memory responder side (returns instruction, ready and error flags)
// The bidirectional dmem data bus is a plain inout port on the responder.
interface cpu_mem_responder_if;
    import mem_pkg::*;

    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_insn;
    logic [WORD_W-1:0] dmem_addr;
    logic              dmem_wen;
    logic              load_valid;
    logic [WORD_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              mem_ready;
    logic              addr_err;

    modport master (
        output imem_addr, dmem_addr, dmem_wen, load_valid, load_data, load_last,
        input  imem_insn, load_ready, mem_ready, addr_err
    );

    modport slave (
        input  imem_addr, dmem_addr, dmem_wen, load_valid, load_data, load_last,
        output imem_insn, load_ready, mem_ready, addr_err
    );

endinterface

// File: rtl/cpu_mem_responder_dp_array.sv
// Synchronous dual-port word RAM.
//   clk               : clock
//   a_addr / a_rdata  : port A, read-only, registered read data
//   b_addr / b_we /
//   b_wdata / b_rdata : port B, read/write, registered read data
// Both ports are read-before-write: a read and a write of the same word on
// the same edge return the old contents.
module mem_dp_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic [AW-1:0]     a_addr,
    output logic [WORD_W-1:0] a_rdata,
    input  logic [AW-1:0]     b_addr,
    input  logic              b_we,
    input  logic [WORD_W-1:0] b_wdata,
    output logic [WORD_W-1:0] b_rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Unified instruction/data memory on the responder side of the CPU.
// After reset a word-stream loader fills the image, then the block serves
// instruction fetches and data reads/writes.
//   clk        : clock
//   rst        : asynchronous active-high reset
//   bus        : CPU address/control, loader stream, ready and error flags
//   dmem_data  : shared data bus, driven by the CPU on writes, by this block on reads
// Memory contents survive reset.
//
//   state | meaning
//   IDLE  | one cycle after reset release
//   LOAD  | accepting loader words, CPU ports ignored
//   RUN   | serving imem/dmem until reset
module cpu_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_INSN    = mem_pkg::NOP_INSN
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_mem_responder_if.slave   bus,
    inout  wire  [31:0]          dmem_data
);
    import mem_pkg::*;

    localparam int            AW       = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_WORDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     load_ptr;
    logic              load_fire;
    logic              run;

    addr_dec_t         imem_dec;
    addr_dec_t         dmem_dec;
    logic              imem_ok;
    logic              dmem_ok;
    logic              unused_dec_hi;

    logic [AW-1:0]     b_addr;
    logic              b_we;
    logic [WORD_W-1:0] b_wdata;
    logic [WORD_W-1:0] a_rdata;
    logic [WORD_W-1:0] b_rdata;

    logic              fetch_ok_q;
    logic              rd_ok_q;
    logic              drv_en;
    logic              addr_err_q;
    logic [WORD_W-1:0] rdata;
    logic              dmem_oe;

    assign imem_dec      = decode_addr(bus.imem_addr, AW);
    assign dmem_dec      = decode_addr(bus.dmem_addr, AW);
    assign imem_ok       = imem_dec.in_range;
    assign dmem_ok       = dmem_dec.in_range;
    // Index bits above AW only matter through the in-range flag.
    assign unused_dec_hi = |{imem_dec.idx[WORD_W-1:AW], dmem_dec.idx[WORD_W-1:AW]};

    assign run       = (state == RUN);
    assign load_fire = bus.load_valid && (state == LOAD);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = LOAD;
            LOAD: begin
                if (load_fire && (bus.load_last || (load_ptr == LAST_PTR))) begin
                    state_nxt = RUN;
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs
    always_comb begin
        bus.load_ready = (state == LOAD);
        bus.mem_ready  = run;
        bus.addr_err   = addr_err_q;
        bus.imem_insn  = fetch_ok_q ? a_rdata : NOP_INSN;
        rdata          = rd_ok_q ? b_rdata : '0;
        // Live dmem_wen gate: release the bus the moment the CPU turns it around.
        dmem_oe        = drv_en && !bus.dmem_wen;
    end

    assign dmem_data = dmem_oe ? rdata : 'z;

    // Saturates at the last word so the pointer never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_ptr <= '0;
        end else if (load_fire && (load_ptr != LAST_PTR)) begin
            load_ptr <= load_ptr + 1'b1;
        end
    end

    // Port B is owned by the loader in LOAD and by dmem in RUN.
    always_comb begin
        b_addr  = dmem_dec.idx[AW-1:0];
        b_we    = 1'b0;
        b_wdata = dmem_data;
        if (state == LOAD) begin
            b_addr  = load_ptr;
            b_we    = load_fire;
            b_wdata = bus.load_data;
        end else if (run) begin
            b_we = bus.dmem_wen && dmem_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_ok_q <= 1'b0;
            rd_ok_q    <= 1'b0;
            drv_en     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            fetch_ok_q <= run && imem_ok;
            rd_ok_q    <= run && !bus.dmem_wen && dmem_ok;
            drv_en     <= run && !bus.dmem_wen;
            if (run && (!imem_ok || !dmem_ok)) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    mem_dp_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .a_addr  (imem_dec.idx[AW-1:0]),
        .a_rdata (a_rdata),
        .b_addr  (b_addr),
        .b_we    (b_we),
        .b_wdata (b_wdata),
        .b_rdata (b_rdata)
    );

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rst4;
    logic        cpu_drv;
    logic [31:0] cpu_wdata;
    wire  [31:0] dmem_data;
    wire  [31:0] dmem_data4;

    assign dmem_data = cpu_drv ? cpu_wdata : 'z;

    cpu_mem_responder_if bus ();
    cpu_mem_responder_if bus4 ();

    cpu_mem_responder #(.DEPTH_WORDS(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dmem_data (dmem_data)
    );

    cpu_mem_responder #(.DEPTH_WORDS(4)) dut4 (
        .clk       (clk),
        .rst       (rst4),
        .bus       (bus4),
        .dmem_data (dmem_data4)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] iq [$];
    logic [31:0] dq [$];
    logic [31:0] kq [$];
    logic i_req = 1'b0, d_req = 1'b0, k_req = 1'b0;
    logic i_pend = 1'b0, d_pend = 1'b0, k_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Responses appear one edge after the request.
    always @(posedge clk) begin
        i_pend <= i_req;
        d_pend <= d_req;
        k_pend <= k_req;
    end

    always @(negedge clk) begin
        if (i_pend) begin
            if (iq.size() == 0) begin
                n_chk++;
                $display("FAIL imem_sb: response with no expected entry, got %h", bus.imem_insn);
            end else begin
                check("imem_insn", bus.imem_insn, iq.pop_front());
            end
        end
        if (d_pend) begin
            check("dmem_drive", {31'd0, dut.dmem_oe}, 32'd1);
            if (dq.size() == 0) begin
                n_chk++;
                $display("FAIL dmem_sb: response with no expected entry, got %h", dmem_data);
            end else begin
                check("dmem_rdata", dmem_data, dq.pop_front());
            end
        end
        if (k_pend) begin
            if (kq.size() == 0) begin
                n_chk++;
                $display("FAIL imem4_sb: response with no expected entry, got %h", bus4.imem_insn);
            end else begin
                check("imem4_insn", bus4.imem_insn, kq.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        i_req = 1'b0;
        d_req = 1'b0;
        k_req = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
        bus.imem_addr = a;
        iq.push_back(exp);
        i_req = 1'b1;
    endtask

    task automatic fetch4(input logic [31:0] a, input logic [31:0] exp);
        bus4.imem_addr = a;
        kq.push_back(exp);
        k_req = 1'b1;
    endtask

    task automatic dread(input logic [31:0] a, input logic [31:0] exp);
        bus.dmem_wen  = 1'b0;
        cpu_drv       = 1'b0;
        bus.dmem_addr = a;
        dq.push_back(exp);
        d_req = 1'b1;
    endtask

    task automatic dwrite(input logic [31:0] a, input logic [31:0] d);
        bus.dmem_wen  = 1'b1;
        cpu_drv       = 1'b1;
        cpu_wdata     = d;
        bus.dmem_addr = a;
    endtask

    task automatic didle(input logic [31:0] a);
        bus.dmem_wen  = 1'b0;
        cpu_drv       = 1'b0;
        bus.dmem_addr = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] w4 [5];

    initial begin
        w4[0] = 32'hA000_0001; w4[1] = 32'hA000_0002; w4[2] = 32'hA000_0003;
        w4[3] = 32'hA000_0004; w4[4] = 32'hA000_0005;

        rst = 1'b1; rst4 = 1'b1; cpu_drv = 1'b0; cpu_wdata = '0;
        bus.imem_addr = '0; bus.dmem_addr = '0; bus.dmem_wen = 1'b0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
        bus4.imem_addr = '0; bus4.dmem_addr = '0; bus4.dmem_wen = 1'b0;
        bus4.load_valid = 1'b0; bus4.load_data = '0; bus4.load_last = 1'b0;
        #1;
        check("rst_imem_insn",  bus.imem_insn, NOP_INSN);
        check("rst_load_ready", {31'd0, bus.load_ready}, 32'd0);
        check("rst_mem_ready",  {31'd0, bus.mem_ready}, 32'd0);
        check("rst_addr_err",   {31'd0, bus.addr_err}, 32'd0);
        check("rst_dmem_drive", {31'd0, dut.dmem_oe}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        step();
        check("load_ready_up", {31'd0, bus.load_ready}, 32'd1);
        check("mem_ready_load", {31'd0, bus.mem_ready}, 32'd0);
        bus.load_valid = 1'b1; bus.load_data = 32'h0050_0093; bus.load_last = 1'b0;
        step();
        check("load_imem_nop", bus.imem_insn, NOP_INSN);
        bus.load_data = 32'h00a0_0113; bus.load_last = 1'b1;
        step();
        check("mem_ready_run",   {31'd0, bus.mem_ready}, 32'd1);
        check("load_ready_down", {31'd0, bus.load_ready}, 32'd0);
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        fetch(32'h0, 32'h0050_0093);
        step(); fetch(32'h4, 32'h00a0_0113);
        step(); bus.imem_addr = '0;

        // write then read; the previous cycle was a read so drv_en is set
        step(); dwrite(32'h40, 32'hDEAD_BEEF);
        #1; check("wr_no_drive", {31'd0, dut.dmem_oe}, 32'd0);
        step(); dread(32'h40, 32'hDEAD_BEEF);
        step(); dread(32'h43, 32'hDEAD_BEEF);
        step(); dwrite(32'h44, 32'hAAAA_5555);
        step(); dwrite(32'h44, 32'h5A5A_A5A5);
        step(); dread(32'h44, 32'h5A5A_A5A5);

        // same-word collision
        step(); dwrite(32'h10, 32'h1111_1111);
        step(); dwrite(32'h10, 32'h2222_2222); fetch(32'h10, 32'h1111_1111);
        step(); didle(32'h10); fetch(32'h10, 32'h2222_2222);
        step(); bus.imem_addr = '0; dread(32'h10, 32'h2222_2222);

        // range
        step(); check("addr_err_clean", {31'd0, bus.addr_err}, 32'd0);
        fetch(32'h1000, NOP_INSN);
        step(); bus.imem_addr = '0;
        check("addr_err_imem", {31'd0, bus.addr_err}, 32'd1);
        dwrite(32'h1040, 32'h0BAD_F00D);
        step(); dread(32'h40, 32'hDEAD_BEEF);
        step(); dread(32'h2000, 32'h0);
        step(); didle(32'h40);
        step(); check("addr_err_sticky", {31'd0, bus.addr_err}, 32'd1);

        // asynchronous reset while the block drives a read
        step();
        check("pre_rst_drive", {31'd0, dut.dmem_oe}, 32'd1);
        check("pre_rst_data", dmem_data, 32'hDEAD_BEEF);
        #1; rst = 1'b1; #1;
        check("arst_drive",      {31'd0, dut.dmem_oe}, 32'd0);
        check("arst_mem_ready",  {31'd0, bus.mem_ready}, 32'd0);
        check("arst_imem_insn",  bus.imem_insn, NOP_INSN);
        check("arst_addr_err",   {31'd0, bus.addr_err}, 32'd0);
        step(); rst = 1'b0;
        step();
        check("reload_ready", {31'd0, bus.load_ready}, 32'd1);
        bus.load_valid = 1'b1; bus.load_data = 32'h1234_5678; bus.load_last = 1'b1;
        step();
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        check("reload_run", {31'd0, bus.mem_ready}, 32'd1);
        fetch(32'h0, 32'h1234_5678); dread(32'h40, 32'hDEAD_BEEF);
        step(); fetch(32'h4, 32'h00a0_0113); dread(32'h10, 32'h2222_2222);
        step(); bus.imem_addr = '0; didle(32'h0);

        // depth limit on a 4-word instance
        step(); rst4 = 1'b0;
        step();
        check("d4_load_ready", {31'd0, bus4.load_ready}, 32'd1);
        bus4.load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus4.load_data = w4[i];
            step();
        end
        check("d4_mem_ready",  {31'd0, bus4.mem_ready}, 32'd1);
        check("d4_load_ready_down", {31'd0, bus4.load_ready}, 32'd0);
        bus4.load_data = w4[4];
        step();
        check("d4_fifth_refused", {31'd0, bus4.load_ready}, 32'd0);
        bus4.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch4(32'(i * 4), w4[i]);
            step();
        end
        fetch4(32'h10, NOP_INSN);
        step(); bus4.imem_addr = '0;
        step();
        step();
        check("sb_drain", 32'(iq.size() + dq.size() + kq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
